step_phase_decoder: RTL and testbench

STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

---
 rtl/step_phase_decoder.sv | 191 +++++++++++++++++++
 tb/tb_step_phase_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_phase_decoder.sv
// Quadrature-style decoder for a monitored 4-phase stepper drive.
// Counts steps and flags skipped/illegal phases, stalls and home events.
module step_phase_decoder #(
  parameter int STALL_LIM = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] step_motor,
  input  logic       motor_sense,
  input  logic       clr,
  output logic [7:0] position,
  output logic       dir,
  output logic       step_pulse,
  output logic       phase_err,
  output logic       stall,
  output logic       homed,
  output logic [1:0] dec_state
);

  // state | meaning
  // IDLE  | drive off (0000), waiting for a legal phase
  // TRACK | following phase changes, counting steps
  // FAULT | illegal/skipped phase seen, frozen until clr
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam int CW = $clog2(STALL_LIM + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(STALL_LIM);

  state_t          state_q, state_d;
  logic [3:0]      motor_s1_q, motor_s2_q;
  logic            sense_s1_q, sense_s2_q, sense_prev_q;
  logic [1:0]      prev_idx_q, prev_idx_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [7:0]      position_q, position_d;
  logic            dir_q, dir_d;
  logic            step_pulse_q, step_pulse_d;
  logic            phase_err_q, phase_err_d;
  logic            stall_q, stall_d;
  logic            homed_q, homed_d;

  logic            code_legal, code_off;
  logic [1:0]      code_idx, step_delta;
  logic            home_edge;

  always_comb begin
    code_legal = 1'b1;
    code_off   = 1'b0;
    code_idx   = 2'd0;
    case (motor_s2_q)
      4'b1100: code_idx = 2'd0;
      4'b0110: code_idx = 2'd1;
      4'b0011: code_idx = 2'd2;
      4'b1001: code_idx = 2'd3;
      4'b0000: begin
        code_legal = 1'b0;
        code_off   = 1'b1;
      end
      default: code_legal = 1'b0;
    endcase
  end

  assign step_delta = code_idx - prev_idx_q;
  assign home_edge  = sense_s2_q & ~sense_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      motor_s1_q   <= 4'd0;
      motor_s2_q   <= 4'd0;
      sense_s1_q   <= 1'b0;
      sense_s2_q   <= 1'b0;
      sense_prev_q <= 1'b0;
      prev_idx_q   <= 2'd0;
      stall_cnt_q  <= '0;
      position_q   <= 8'd0;
      dir_q        <= 1'b1;
      step_pulse_q <= 1'b0;
      phase_err_q  <= 1'b0;
      stall_q      <= 1'b0;
      homed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      motor_s1_q   <= step_motor;
      motor_s2_q   <= motor_s1_q;
      sense_s1_q   <= motor_sense;
      sense_s2_q   <= sense_s1_q;
      sense_prev_q <= sense_s2_q;
      prev_idx_q   <= prev_idx_d;
      stall_cnt_q  <= stall_cnt_d;
      position_q   <= position_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
      phase_err_q  <= phase_err_d;
      stall_q      <= stall_d;
      homed_q      <= homed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (code_legal)     state_d = TRACK;
          else if (!code_off) state_d = FAULT;
        end
        TRACK: begin
          if (code_off)                              state_d = IDLE;
          else if (!code_legal || step_delta == 2'd2) state_d = FAULT;
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    prev_idx_d   = prev_idx_q;
    stall_cnt_d  = stall_cnt_q;
    position_d   = position_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
    phase_err_d  = phase_err_q;
    stall_d      = stall_q;
    homed_d      = homed_q;
    if (clr) begin
      stall_cnt_d = '0;
      position_d  = 8'd0;
      phase_err_d = 1'b0;
      stall_d     = 1'b0;
      homed_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (code_legal)     prev_idx_d  = code_idx;
          else if (!code_off) phase_err_d = 1'b1;
        end
        TRACK: begin
          if (code_off) begin
            stall_cnt_d = '0;
          end else if (!code_legal) begin
            phase_err_d = 1'b1;
          end else begin
            case (step_delta)
              2'd1: begin
                position_d   = position_q + 8'd1;
                dir_d        = 1'b1;
                step_pulse_d = 1'b1;
                prev_idx_d   = code_idx;
                stall_cnt_d  = '0;
              end
              2'd3: begin
                position_d   = position_q - 8'd1;
                dir_d        = 1'b0;
                step_pulse_d = 1'b1;
                prev_idx_d   = code_idx;
                stall_cnt_d  = '0;
              end
              2'd2: phase_err_d = 1'b1;
              default: begin
                if (stall_cnt_q != CNT_LIM) stall_cnt_d = stall_cnt_q + CW'(1);
                if (stall_cnt_d == CNT_LIM) stall_d = 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
      // Home overrides the count but leaves dir/step_pulse from a same-cycle step.
      if (home_edge && state_q != FAULT) begin
        position_d = 8'd0;
        homed_d    = 1'b1;
      end
    end
  end

  assign position   = position_q;
  assign dir        = dir_q;
  assign step_pulse = step_pulse_q;
  assign phase_err  = phase_err_q;
  assign stall      = stall_q;
  assign homed      = homed_q;
  assign dec_state  = state_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Self-checking bench for step_phase_decoder: directed scenarios plus random
// phase activity, compared every cycle against a behavioural model.
`timescale 1us/1ns
module tb_step_phase_decoder;
  localparam int LIM = 12;

  logic       clk = 1'b0;
  logic       rst, clr, motor_sense;
  logic [3:0] step_motor;
  logic [7:0] position;
  logic       dir, step_pulse, phase_err, stall, homed;
  logic [1:0] dec_state;

  step_phase_decoder #(.STALL_LIM(LIM)) dut (
    .clk(clk), .rst(rst), .step_motor(step_motor), .motor_sense(motor_sense),
    .clr(clr), .position(position), .dir(dir), .step_pulse(step_pulse),
    .phase_err(phase_err), .stall(stall), .homed(homed), .dec_state(dec_state)
  );

  always #500 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_pulses = 0;

  logic [3:0] codes [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

  // model: mode 0 idle, 1 tracking, 2 faulted
  int m_pos, m_dir, m_pulse, m_err, m_stall, m_homed, m_mode, m_prev, m_cnt;
  logic [3:0] s1, s2;
  logic e1, e2, ep;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int phase_index(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (codes[i] == c) return i;
    if (c == 4'b0000) return -1;
    return -2;
  endfunction

  task automatic model_edge();
    int idx, d, old_mode;
    bit home;
    if (!rst) begin
      m_pos = 0; m_dir = 1; m_pulse = 0; m_err = 0; m_stall = 0; m_homed = 0;
      m_mode = 0; m_prev = 0; m_cnt = 0;
      s1 = 0; s2 = 0; e1 = 0; e2 = 0; ep = 0;
    end else begin
      home = e2 && !ep;
      idx = phase_index(s2);
      old_mode = m_mode;
      m_pulse = 0;
      if (clr) begin
        m_pos = 0; m_err = 0; m_stall = 0; m_homed = 0; m_cnt = 0; m_mode = 0;
      end else begin
        if (old_mode == 0) begin
          if (idx == -2) begin m_err = 1; m_mode = 2; end
          else if (idx >= 0) begin m_prev = idx; m_mode = 1; end
        end else if (old_mode == 1) begin
          if (idx == -1) begin
            m_mode = 0; m_cnt = 0;
          end else if (idx == -2) begin
            m_err = 1; m_mode = 2;
          end else begin
            d = (idx - m_prev + 4) % 4;
            if (d == 1) begin
              m_pos = (m_pos + 1) % 256; m_dir = 1; m_pulse = 1; m_prev = idx; m_cnt = 0;
            end else if (d == 3) begin
              m_pos = (m_pos + 255) % 256; m_dir = 0; m_pulse = 1; m_prev = idx; m_cnt = 0;
            end else if (d == 2) begin
              m_err = 1; m_mode = 2;
            end else begin
              if (m_cnt < LIM) m_cnt++;
              if (m_cnt == LIM) m_stall = 1;
            end
          end
        end
        if (home && old_mode != 2) begin m_pos = 0; m_homed = 1; end
      end
      ep = e2; e2 = e1; e1 = motor_sense; s2 = s1; s1 = step_motor;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("position", position, m_pos);
    chk("dir", dir, m_dir);
    chk("step_pulse", step_pulse, m_pulse);
    chk("phase_err", phase_err, m_err);
    chk("stall", stall, m_stall);
    chk("homed", homed, m_homed);
    chk("dec_state", dec_state, m_mode);
    if (step_pulse === 1'b1) dut_pulses++;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [3:0] c, input int n);
    step_motor = c;
    cycles(n);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int cur, r, p;
    rst = 1'b0; clr = 1'b0; motor_sense = 1'b0; step_motor = 4'b0000;
    cycles(2);
    chk("reset_pos", position, 0);
    chk("reset_dir", dir, 1);
    chk("reset_state", dec_state, 0);
    rst = 1'b1;
    cycles(2);

    // full forward revolution
    dut_pulses = 0;
    drive(4'b0000, 5); drive(4'b1100, 5); drive(4'b0110, 5);
    drive(4'b0011, 5); drive(4'b1001, 5); drive(4'b1100, 5);
    cycles(3);
    chk("rev_pos", position, 4);
    chk("rev_dir", dir, 1);
    chk("rev_pulses", dut_pulses, 4);

    // wrap below zero and back
    pulse_clr();
    cycles(3);
    chk("wrap_start", position, 0);
    drive(4'b1001, 5);
    chk("wrap_down", position, 255);
    chk("wrap_dir", dir, 0);
    drive(4'b1100, 5);
    chk("wrap_up", position, 0);

    // skipped phase faults and freezes
    drive(4'b0011, 5);
    chk("skip_err", phase_err, 1);
    chk("skip_state", dec_state, 2);
    drive(4'b0110, 5); drive(4'b1100, 5);
    chk("fault_frozen", position, 0);
    chk("fault_state", dec_state, 2);
    pulse_clr();
    chk("clr_state", dec_state, 0);
    chk("clr_err", phase_err, 0);
    chk("clr_pos", position, 0);
    cycles(3);

    // homing at position 7, then home coincident with a step
    for (int i = 1; i <= 7; i++) drive(codes[i % 4], 4);
    chk("pos7", position, 7);
    motor_sense = 1'b1; cycles(3);
    motor_sense = 1'b0; cycles(4);
    chk("home_pos", position, 0);
    chk("home_flag", homed, 1);
    drive(4'b1100, 4);
    chk("pre_home_step", position, 1);
    step_motor = 4'b0110; motor_sense = 1'b1;
    cycles(3);
    chk("home_step_pos", position, 0);
    chk("home_step_pulse", step_pulse, 1);
    motor_sense = 1'b0;
    cycles(4);

    // stall detection
    drive(4'b0011, 4);
    step_motor = 4'b0110;
    cycles(3 + LIM - 1);
    chk("stall_early", stall, 0);
    tick();
    chk("stall_set", stall, 1);
    cycles(5);
    drive(4'b0011, 5);
    chk("stall_sticky", stall, 1);
    pulse_clr();
    chk("stall_clr", stall, 0);
    cycles(3);

    // reset mid-step at position 50
    for (int i = 1; i <= 50; i++) drive(codes[(2 + i) % 4], 3);
    chk("pos50", position, 50);
    step_motor = codes[1]; // next forward phase after codes[0]
    cycles(2);
    rst = 1'b0;
    tick();
    chk("rst_pos", position, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_dir", dir, 1);
    chk("rst_state", dec_state, 0);
    rst = 1'b1;
    dut_pulses = 0;
    cycles(6);
    chk("post_rst_nocount", dut_pulses, 0);
    chk("post_rst_track", dec_state, 1);

    // random activity
    cur = 1;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      cur = (cur + 1) % 4;
      else if (r < 60) cur = (cur + 3) % 4;
      else if (r < 63) cur = (cur + 2) % 4;
      if (r >= 63 && r < 66) step_motor = 4'($urandom_range(0, 15));
      else if (r >= 66 && r < 70) step_motor = 4'b0000;
      else step_motor = codes[cur];
      if ($urandom_range(0, 19) == 0) motor_sense = ~motor_sense;
      p = $urandom_range(0, 199);
      if (p < 4) clr = 1'b1;
      else if (p == 4) rst = 1'b0;
      tick();
      clr = 1'b0; rst = 1'b1;
      cycles($urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
